spi_response_serializer: RTL

Transmit side of the host SPI link. Takes a decoded read request (register address) from the main control logic, snapshots the addressed FPGA register (status, image count, JPEG size, last error), and serializes a framed response one byte at a time to the SPI slave transmit path under a valid/ready handshake. It complements the receive-side instruction/data buffer and sits between the main control block and the SPI block.

---
 rtl/spi_resp_pkg.sv | 34 +++
 rtl/spi_resp_snapshot.sv | 49 ++++
 rtl/spi_response_serializer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_resp_pkg.sv
// Shared constants and types for the SPI response serializer.
package spi_resp_pkg;

  localparam logic [7:0] ADDR_STATUS  = 8'h10;
  localparam logic [7:0] ADDR_NUMIMG  = 8'h11;
  localparam logic [7:0] ADDR_JPGSIZE = 8'h12;
  localparam logic [7:0] ADDR_ERROR   = 8'h13;
  localparam logic [7:0] HDR_UNKNOWN  = 8'hFF;

  localparam int MAX_LEN   = 3;
  localparam int PAYLOAD_W = MAX_LEN * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  // Pick payload byte number idx (0 = least significant) out of the right-aligned payload vector.
  function automatic logic [7:0] payload_byte(input logic [PAYLOAD_W-1:0] payload,
                                              input logic [1:0] idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = payload[7:0];
      2'd1:    sel = payload[15:8];
      2'd2:    sel = payload[23:16];
      default: sel = 8'h00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/spi_resp_snapshot.sv
// Address decode: turns a register address into the frame header, payload length
// and a right-aligned payload vector (most significant byte is transmitted first).
module spi_resp_snapshot
  import spi_resp_pkg::*;
(
  input  logic [7:0]           addr,
  input  logic [3:0]           status_bits,
  input  logic [15:0]          num_img_stored,
  input  logic [23:0]          jpg_size,
  input  logic [15:0]          err_index,
  input  logic                 err_camid,
  input  logic [5:0]           err_flags,
  output logic [7:0]           hdr,
  output logic [1:0]           len,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 unknown
);

  // Map each known address to its length and payload; anything else becomes an empty frame.
  always_comb begin
    hdr     = addr;
    len     = 2'd0;
    payload = '0;
    unknown = 1'b0;
    case (addr)
      ADDR_STATUS: begin
        len     = 2'd1;
        payload = {16'h0000, 4'h0, status_bits};
      end
      ADDR_NUMIMG: begin
        len     = 2'd2;
        payload = {8'h00, num_img_stored};
      end
      ADDR_JPGSIZE: begin
        len     = 2'd3;
        payload = jpg_size;
      end
      ADDR_ERROR: begin
        len     = 2'd3;
        payload = {err_index, err_camid, 1'b0, err_flags};
      end
      default: begin
        hdr     = HDR_UNKNOWN;
        unknown = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/spi_response_serializer.sv
// Serializes a framed register read response (HDR, LEN, payload, XOR checksum)
// to the SPI transmit path over a valid/ready handshake.
module spi_response_serializer
  import spi_resp_pkg::*;
(
  input  logic        sysClk,
  input  logic        sysRst_n,
  input  logic        read_req,
  input  logic [7:0]  read_addr,
  input  logic        spi_cs_active,
  input  logic [3:0]  status_bits,
  input  logic [15:0] num_img_stored,
  input  logic [23:0] jpg_size,
  input  logic [15:0] err_index,
  input  logic        err_camid,
  input  logic [5:0]  err_flags,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        req_dropped,
  output logic        unknown_addr
);

  state_t               state;
  state_t               next_state;

  logic [7:0]           dec_hdr;
  logic [1:0]           dec_len;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic                 dec_unknown;

  logic [7:0]           snap_hdr;
  logic [1:0]           snap_len;
  logic [PAYLOAD_W-1:0] snap_payload;
  logic [1:0]           byte_cnt;
  logic [7:0]           csum;

  logic                 accept;
  logic                 aborting;
  logic                 handshake;

  spi_resp_snapshot u_snapshot (
    .addr           (read_addr),
    .status_bits    (status_bits),
    .num_img_stored (num_img_stored),
    .jpg_size       (jpg_size),
    .err_index      (err_index),
    .err_camid      (err_camid),
    .err_flags      (err_flags),
    .hdr            (dec_hdr),
    .len            (dec_len),
    .payload        (dec_payload),
    .unknown        (dec_unknown)
  );

  // A dropped chip-select wins over any handshake in the same cycle.
  assign accept    = (state == ST_IDLE) && read_req;
  assign aborting  = (state != ST_IDLE) && !spi_cs_active;
  assign handshake = tx_valid && tx_ready && spi_cs_active;

  // State register.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) state <= ST_IDLE;
    else           state <= next_state;
  end

  // Frame sequencing; each step waits for a completed handshake, abort overrides all.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (read_req)  next_state = ST_HDR;
      ST_HDR:     if (handshake) next_state = ST_LEN;
      ST_LEN:     if (handshake) next_state = (snap_len == 2'd0) ? ST_CSUM : ST_PAYLOAD;
      ST_PAYLOAD: if (handshake && (byte_cnt == 2'd0)) next_state = ST_CSUM;
      ST_CSUM:    if (handshake) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (aborting) next_state = ST_IDLE;
  end

  // Byte presented in each state; depends only on registered values so it holds while stalled.
  always_comb begin
    tx_byte  = 8'h00;
    tx_valid = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_HDR: begin
        tx_byte  = snap_hdr;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      ST_LEN: begin
        tx_byte  = {6'b000000, snap_len};
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      ST_PAYLOAD: begin
        tx_byte  = payload_byte(snap_payload, byte_cnt);
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      ST_CSUM: begin
        tx_byte  = csum;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        tx_byte  = 8'h00;
        tx_valid = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Snapshot capture on accept, running checksum and payload countdown on each accepted byte.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      snap_hdr     <= 8'h00;
      snap_len     <= 2'd0;
      snap_payload <= '0;
      byte_cnt     <= 2'd0;
      csum         <= 8'h00;
    end else if (accept) begin
      snap_hdr     <= dec_hdr;
      snap_len     <= dec_len;
      snap_payload <= dec_payload;
      byte_cnt     <= 2'd0;
      csum         <= 8'h00;
    end else if (aborting) begin
      snap_hdr     <= 8'h00;
      snap_len     <= 2'd0;
      snap_payload <= '0;
      byte_cnt     <= 2'd0;
      csum         <= 8'h00;
    end else if (handshake) begin
      if (state != ST_CSUM) csum <= csum ^ tx_byte;
      if ((state == ST_LEN) && (snap_len != 2'd0)) byte_cnt <= snap_len - 2'd1;
      if ((state == ST_PAYLOAD) && (byte_cnt != 2'd0)) byte_cnt <= byte_cnt - 2'd1;
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      frame_done   <= 1'b0;
      req_dropped  <= 1'b0;
      unknown_addr <= 1'b0;
    end else begin
      frame_done   <= handshake && (state == ST_CSUM);
      req_dropped  <= read_req && (state != ST_IDLE);
      unknown_addr <= accept && dec_unknown;
    end
  end

endmodule
